// File: rtl/gcd_dispatch.sv
// gcd_dispatch: round-robin scheduler sharing NW gcd_thread workers among NREQ requesters.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req_valid/req_a/req_b    per-requester operand pair, slice [r*W +: W]
//   req_ready                combinational accept strobe, at most one bit high
//   rsp_valid/rsp_data       registered one-cycle result pulse; data held until next pulse
//   wk_load/wk_val           per-worker load strobe and operand bus (A then B)
//   wk_out/wk_done           per-worker result and completion flag
module gcd_dispatch #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned NW   = 2,
   parameter int unsigned W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [NREQ*W-1:0] rsp_data,
   output logic [NW-1:0]     wk_load,
   output logic [NW*W-1:0]   wk_val,
   input  logic [NW*W-1:0]   wk_out,
   input  logic [NW-1:0]     wk_done
);

   localparam int unsigned RW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned SW = RW + 1;
   localparam int unsigned TW = (NW > 1) ? $clog2(NW) : 1;

   typedef enum logic [1:0] {StIdle, StLoad, StSendA, StSendB} state_e;

   state_e              state_q, state_d;
   logic [NW-1:0]       busy_q, busy_d;
   logic [RW-1:0]       owner_q [NW];
   logic [RW-1:0]       owner_d [NW];
   logic [NREQ-1:0]     pend_q, pend_d;
   logic [RW-1:0]       rr_q, rr_d;
   logic [W-1:0]        opa_q, opa_d;
   logic [W-1:0]        opb_q, opb_d;
   logic [TW-1:0]       tw_q, tw_d;
   logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
   logic [NREQ*W-1:0]   rsp_data_q, rsp_data_d;
   logic [NW-1:0]       wk_load_q, wk_load_d;

   logic [NREQ-1:0]     elig;
   logic [SW-1:0]       rr_sum;
   logic                grant_vld;
   logic [RW-1:0]       grant_idx;
   logic                free_vld;
   logic [TW-1:0]       free_idx;
   logic                accept;

   // Arbitration: first eligible requester at or after rr, lowest free worker.
   always_comb begin
      elig      = req_valid & ~pend_q;
      rr_sum    = '0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
         rr_sum = {1'b0, rr_q} + SW'(k);
         if (rr_sum >= SW'(NREQ)) begin
            rr_sum = rr_sum - SW'(NREQ);
         end
         if (!grant_vld && elig[rr_sum[RW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = rr_sum[RW-1:0];
         end
      end
      free_vld = 1'b0;
      free_idx = '0;
      for (int w = 0; w < int'(NW); w++) begin
         if (!free_vld && !busy_q[w]) begin
            free_vld = 1'b1;
            free_idx = TW'(w);
         end
      end
      // Gated by rst so every output reads zero while reset is held.
      accept    = (state_q == StIdle) && grant_vld && free_vld && !rst;
      req_ready = '0;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Next state: completions are handled per worker, independent of the dispatch FSM.
   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      owner_d     = owner_q;
      pend_d      = pend_q;
      rr_d        = rr_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      tw_d        = tw_q;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      wk_load_d   = '0;

      for (int w = 0; w < int'(NW); w++) begin
         if (wk_done[w] && busy_q[w]) begin
            rsp_valid_d[owner_q[w]]         = 1'b1;
            rsp_data_d[owner_q[w]*W +: W]   = wk_out[w*W +: W];
            busy_d[w]                       = 1'b0;
            pend_d[owner_q[w]]              = 1'b0;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               opa_d               = req_a[grant_idx*W +: W];
               opb_d               = req_b[grant_idx*W +: W];
               tw_d                = free_idx;
               owner_d[free_idx]   = grant_idx;
               busy_d[free_idx]    = 1'b1;
               pend_d[grant_idx]   = 1'b1;
               rr_d                = (grant_idx == RW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
               wk_load_d[free_idx] = 1'b1;
               state_d             = StLoad;
            end
         end
         StLoad:  state_d = StSendA;
         StSendA: state_d = StSendB;
         StSendB: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wk_val = '0;
      if (state_q == StSendA) begin
         wk_val[tw_q*W +: W] = opa_q;
      end else if (state_q == StSendB) begin
         wk_val[tw_q*W +: W] = opb_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         busy_q      <= '0;
         pend_q      <= '0;
         rr_q        <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         tw_q        <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         wk_load_q   <= '0;
         for (int w = 0; w < int'(NW); w++) begin
            owner_q[w] <= '0;
         end
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         pend_q      <= pend_d;
         rr_q        <= rr_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         tw_q        <= tw_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         wk_load_q   <= wk_load_d;
         for (int w = 0; w < int'(NW); w++) begin
            owner_q[w] <= owner_d[w];
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign wk_load   = wk_load_q;

endmodule

// File: tb/tb_gcd_dispatch.sv
// Bench for gcd_dispatch: behavioural gcd workers plus a per-requester scoreboard.
module tb_gcd_dispatch;

   localparam int unsigned NREQ = 4;
   localparam int unsigned NW   = 2;
   localparam int unsigned W    = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a, req_b;
   logic [NREQ-1:0]   req_ready, rsp_valid;
   logic [NREQ*W-1:0] rsp_data;
   logic [NW-1:0]     wk_load, wk_done;
   logic [NW*W-1:0]   wk_val, wk_out;
   logic [NW-1:0]     stray;

   gcd_dispatch #(.NREQ(NREQ), .NW(NW), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .wk_load   (wk_load),
      .wk_val    (wk_val),
      .wk_out    (wk_out),
      .wk_done   (wk_done)
   );

   always #5 clk = ~clk;

   function automatic void ref_gcd(input int unsigned a, input int unsigned b,
                                   output int unsigned g, output int unsigned s);
      int unsigned t;
      s = 0;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
         s++;
      end
      g = a;
   endfunction

   // Worker model: load, capture A, capture B, then done in cycle t+7+s (one-cycle pulse).
   int unsigned  wm_stage [NW];
   int unsigned  wm_cnt   [NW];
   logic [W-1:0] wm_a     [NW];
   logic [W-1:0] wm_res   [NW];

   always @(posedge clk or posedge rst) begin : p_wm
      int unsigned g, s;
      if (rst) begin
         for (int w = 0; w < int'(NW); w++) begin
            wm_stage[w] <= 0;
            wm_cnt[w]   <= 0;
            wm_a[w]     <= '0;
            wm_res[w]   <= '0;
         end
      end else begin
         for (int w = 0; w < int'(NW); w++) begin
            if (wk_load[w]) begin
               wm_stage[w] <= 1;
            end else if (wm_stage[w] == 1) begin
               wm_a[w]     <= wk_val[w*W +: W];
               wm_stage[w] <= 2;
            end else if (wm_stage[w] == 2) begin
               ref_gcd(int'(wm_a[w]), int'(wk_val[w*W +: W]), g, s);
               wm_res[w]   <= g[W-1:0];
               wm_cnt[w]   <= s + 3;
               wm_stage[w] <= 3;
            end else if (wm_stage[w] == 3) begin
               if (wm_cnt[w] == 0) wm_stage[w] <= 0;
               else wm_cnt[w] <= wm_cnt[w] - 1;
            end
         end
      end
   end

   for (genvar w = 0; w < int'(NW); w++) begin : g_wm
      assign wk_done[w]        = (wm_stage[w] == 3 && wm_cnt[w] == 0) | stray[w];
      assign wk_out[w*W +: W]  = wm_res[w];
   end

   typedef struct {
      int unsigned res;
      int unsigned s;
      int unsigned acc;
   } exp_t;

   exp_t            exp_q [NREQ][$];
   int unsigned     acc_log[$];
   int unsigned     cyc;
   int unsigned     acc_cyc [NREQ];
   int unsigned     last_rsp_cyc [NREQ];
   logic [NREQ-1:0] s_ready, s_rspv, simul_mask;
   logic [NW-1:0]   s_load, last_load;
   logic [NW*W-1:0] s_val;
   int unsigned     n_vec = 0;
   int unsigned     n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  tag, got, got, want, want, cyc);
      end
   endtask

   function automatic int unsigned pending();
      int unsigned n = 0;
      for (int r = 0; r < int'(NREQ); r++) n += exp_q[r].size();
      return n;
   endfunction

   // One clock: sample at negedge, score, then retire accepted requests after the edge.
   task automatic tick();
      logic [NREQ-1:0] acc;
      int unsigned g, s;
      exp_t e;
      @(negedge clk);
      cyc++;
      s_ready = req_ready;
      s_load  = wk_load;
      s_val   = wk_val;
      s_rspv  = rsp_valid;
      if (wk_load != '0) last_load = wk_load;
      if ($countones(rsp_valid) > 1) simul_mask = rsp_valid;
      check("ready_onehot0", 32'($countones(req_ready) <= 1), 1);
      check("ready_wo_valid", 32'(req_ready & ~req_valid), 0);
      for (int r = 0; r < int'(NREQ); r++) begin
         if (rsp_valid[r]) begin
            last_rsp_cyc[r] = cyc;
            if (exp_q[r].size() == 0) begin
               check("rsp_unexpected", r + 1, 0);
            end else begin
               e = exp_q[r].pop_front();
               check("rsp_data", 32'(rsp_data[r*W +: W]), e.res);
               check("rsp_latency", cyc - e.acc, 8 + e.s);
            end
         end
      end
      acc = req_valid & req_ready;
      for (int r = 0; r < int'(NREQ); r++) begin
         if (acc[r]) begin
            ref_gcd(int'(req_a[r*W +: W]), int'(req_b[r*W +: W]), g, s);
            e.res = g;
            e.s   = s;
            e.acc = cyc;
            exp_q[r].push_back(e);
            acc_log.push_back(r);
            acc_cyc[r] = cyc;
         end
      end
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
   endtask

   task automatic set_req(input int unsigned r, input int unsigned a, input int unsigned b);
      req_a[r*W +: W] = W'(a);
      req_b[r*W +: W] = W'(b);
      req_valid[r]    = 1'b1;
   endtask

   task automatic wait_drain(input int unsigned max_cyc);
      int unsigned n = 0;
      while (pending() != 0 && n < max_cyc) begin
         tick();
         n++;
      end
      if (pending() != 0) check("drain_timeout", pending(), 0);
   endtask

   task automatic wait_accepts(input int unsigned max_cyc);
      int unsigned n = 0;
      while (req_valid != '0 && n < max_cyc) begin
         tick();
         n++;
      end
      if (req_valid != '0) check("accept_timeout", 32'(req_valid), 0);
   endtask

   int unsigned za [5] = '{5, 0, 0, 255, 1};
   int unsigned zb [5] = '{0, 7, 0, 255, 255};
   int unsigned zg [5] = '{5, 7, 0, 255, 1};

   initial begin : p_main
      int unsigned t0, r;
      rst = 1'b1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      stray = '0;
      cyc = 0;
      simul_mask = '0;
      last_load = '0;
      tick();
      check("rst_rsp_valid", 32'(s_rspv), 0);
      check("rst_wk_load", 32'(s_load), 0);
      check("rst_wk_val", 32'(s_val), 0);
      check("rst_req_ready", 32'(s_ready), 0);
      check("rst_rsp_data", 32'(rsp_data), 0);
      rst = 1'b0;
      tick();

      // Single job with cycle-exact worker sequence.
      set_req(0, 12, 8);
      tick();
      t0 = cyc;
      check("single_ready", 32'(s_ready), 4'b0001);
      tick();
      check("single_load", 32'(s_load), 2'b01);
      check("single_val_t1", 32'(s_val), 0);
      tick();
      check("single_val_a", 32'(s_val), 16'h000c);
      check("single_load_t2", 32'(s_load), 0);
      tick();
      check("single_val_b", 32'(s_val), 16'h0008);
      wait_drain(60);
      check("single_rsp_cycle", last_rsp_cyc[0] - t0, 10);
      check("single_rsp_data", 32'(rsp_data[7:0]), 4);

      // Zero and extreme operands; last job on r3 leaves rr at 0.
      for (int i = 0; i < 5; i++) begin
         r = (i + 3) % NREQ;
         set_req(r, za[i], zb[i]);
         wait_accepts(20);
         wait_drain(80);
         check("zero_ops_rsp", 32'(rsp_data[r*W +: W]), zg[i]);
      end

      // Round-robin across all requesters with two workers.
      acc_log.delete();
      set_req(0, 48, 18);
      set_req(1, 100, 75);
      set_req(2, 17, 5);
      set_req(3, 81, 27);
      wait_accepts(100);
      wait_drain(100);
      check("rr_count", acc_log.size(), 4);
      for (int i = 0; i < 4 && i < acc_log.size(); i++) check("rr_order", acc_log[i], i);
      check("rr_gap_r1", acc_cyc[1] - acc_cyc[0], 4);
      check("rr_gap_r2", acc_cyc[2] - acc_cyc[0], 11);
      check("rr_gap_r3", acc_cyc[3] - acc_cyc[0], 15);

      // Pool exhaustion: r2 waits until the first worker frees.
      set_req(0, 233, 144);
      set_req(1, 233, 144);
      set_req(2, 12, 8);
      wait_accepts(100);
      wait_drain(100);
      check("exh_wait", acc_cyc[2] - acc_cyc[0], 19);
      check("exh_after_rsp", acc_cyc[2], last_rsp_cyc[0]);
      check("exh_lowest_free", 32'(last_load), 2'b01);

      // Simultaneous completion on both workers (rr is 3 here).
      simul_mask = '0;
      set_req(3, 42, 26);
      set_req(0, 9, 6);
      wait_accepts(40);
      wait_drain(60);
      check("simul_mask", 32'(simul_mask), 4'b1001);
      check("simul_data_r3", 32'(rsp_data[3*W +: W]), 2);
      check("simul_data_r0", 32'(rsp_data[0 +: W]), 3);

      // Reset mid-compute drops the job; stray done afterwards is ignored.
      set_req(0, 233, 144);
      wait_accepts(20);
      repeat (8) tick();
      rst = 1'b1;
      for (int i = 0; i < int'(NREQ); i++) exp_q[i].delete();
      tick();
      check("mid_rst_rsp_valid", 32'(s_rspv), 0);
      check("mid_rst_wk_load", 32'(s_load), 0);
      check("mid_rst_wk_val", 32'(s_val), 0);
      check("mid_rst_rsp_data", 32'(rsp_data), 0);
      rst = 1'b0;
      stray = 2'b11;
      tick();
      stray = '0;
      repeat (30) tick();
      acc_log.delete();
      set_req(0, 12, 8);
      set_req(1, 5, 0);
      tick();
      check("post_rst_accepts", acc_log.size(), 1);
      if (acc_log.size() > 0) check("post_rst_rr0", acc_log[0], 0);
      tick();
      check("post_rst_load_w0", 32'(s_load), 2'b01);
      wait_accepts(20);
      wait_drain(60);
      check("post_rst_r1_data", 32'(rsp_data[1*W +: W]), 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : p_watchdog
      #500000;
      $display("FAIL watchdog: simulation did not reach the summary, cycle %0d", cyc);
      $fatal(1);
   end

endmodule
